// File: rtl/ahb2_slv_mem.sv
// AHB2 slave RAM: configurable width/depth, programmable wait states,
// little-endian byte-lane writes and the two-cycle ERROR response.
module ahb2_slv_mem #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hreadyi,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyo,
  output logic [1:0]        hresp
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BL    = $clog2(BYTES);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  write_q;
  logic [DEPTH_LOG2-1:0] word_q;
  logic [BYTES-1:0]      lanes_q;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  accept;
  logic                  complete;
  logic                  xfer_err;
  logic                  size_err;
  logic                  align_err;
  logic                  range_err;
  logic [BL-1:0]         lo;
  logic [BL-1:0]         sz_mask;
  logic [BYTES-1:0]      lanes;
  logic                  unused_ok;

  assign unused_ok = ^{hburst, hprot, htrans[0]};

  // Classify the address phase currently on the bus.
  always_comb begin
    lo        = haddr[BL-1:0];
    sz_mask   = BL'((32'd1 << hsize) - 32'd1);
    size_err  = (hsize > 3'(BL));
    align_err = |(lo & sz_mask);
    range_err = |haddr[ADDR_W-1:BL+DEPTH_LOG2];
    xfer_err  = size_err | align_err | range_err;
    lanes     = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      lanes[i] = (i >= 32'(lo)) && (i < 32'(lo) + (32'd1 << hsize));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hreadyo = 1'b1;
    hresp   = 2'b00;
    unique case (state_q)
      ST_WAIT: hreadyo = 1'b0;
      ST_ERR1: begin
        hreadyo = 1'b0;
        hresp   = 2'b01;
      end
      ST_ERR2: hresp = 2'b01;
      default: ;
    endcase
    accept   = hsel & hreadyi & htrans[1] & hreadyo;
    complete = pend_q & (state_q == ST_IDLE);
    unique case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE and ERR2 both take a new address phase; a pending good
        // data phase in IDLE completes in this same cycle.
        pend_d  = accept & ~xfer_err;
        state_d = ST_IDLE;
        if (accept) begin
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      word_q  <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (accept) begin
        write_q <= hwrite;
        word_q  <= haddr[BL +: DEPTH_LOG2];
        lanes_q <= lanes;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (complete && write_q) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (lanes_q[i]) mem[word_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Combinational read so a read right behind a write sees the new bytes.
  assign hrdata = (complete && !write_q) ? mem[word_q] : '0;

endmodule

// File: tb/tb_ahb2_slv_mem.sv
// Bench for ahb2_slv_mem: three configurations, directed vector tables and
// randomized traffic checked against a byte-addressed reference memory.
module tb_ahb2_slv_mem;
  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_NS   = 2'b10;
  localparam logic [1:0] TR_SQ   = 2'b11;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    bit          has_exp;
    bit          exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [2:0]  hsel_v = '0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = 3'b001;
  logic [3:0]  hprot = 4'b0011;
  logic [63:0] hwdata = '0;
  logic [2:0]  rdy;
  logic [1:0]  resp0, resp1, resp2;
  logic [31:0] rdata0, rdata1;
  logic [63:0] rdata2;

  int errors = 0;
  int checks = 0;
  vec_t seq[$];
  bit [7:0] mdl [longint];

  always #5 hclk = ~hclk;

  ahb2_slv_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) u0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata[31:0]),
    .hreadyi(rdy[0]), .hrdata(rdata0), .hreadyo(rdy[0]), .hresp(resp0));

  ahb2_slv_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_STATES(3)) u1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata[31:0]),
    .hreadyi(rdy[1]), .hrdata(rdata1), .hreadyo(rdy[1]), .hresp(resp1));

  ahb2_slv_mem #(.DATA_W(64), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_STATES(2)) u2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hreadyi(rdy[2]), .hrdata(rdata2), .hreadyo(rdy[2]), .hresp(resp2));

  function automatic int bytes_of(input int inst);
    return (inst == 2) ? 8 : 4;
  endfunction
  function automatic int lg_of(input int inst);
    return (inst == 2) ? 3 : 2;
  endfunction
  function automatic int dlog_of(input int inst);
    return (inst == 2) ? 8 : 10;
  endfunction
  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : (inst == 1) ? 3 : 2;
  endfunction

  function automatic vec_t mk(input bit sel, input logic [1:0] tr, input bit wr,
                              input logic [2:0] sz, input logic [31:0] a, input logic [63:0] wd,
                              input bit he, input bit ee, input logic [63:0] er);
    vec_t v;
    v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
    v.has_exp = he; v.exp_err = ee; v.exp_rdata = er;
    return v;
  endfunction

  function automatic longint key(input int inst, input logic [31:0] a);
    return (longint'(inst) << 32) | longint'({32'd0, a});
  endfunction

  // Reference classification straight from the address/size rules.
  function automatic bit model_err(input int inst, input logic [2:0] sz, input logic [31:0] a);
    longint nb, nbytes, words, aa;
    nb     = longint'(1) << sz;
    nbytes = longint'(bytes_of(inst));
    words  = longint'(1) << dlog_of(inst);
    aa     = longint'({32'd0, a});
    return (nb > nbytes) || ((aa % nb) != 0) || ((aa / nbytes) >= words);
  endfunction

  task automatic model_write(input int inst, input logic [2:0] sz, input logic [31:0] a,
                             input logic [63:0] wd);
    int nb;
    logic [31:0] b;
    nb = 1 << sz;
    for (int j = 0; j < nb; j++) begin
      b = a + 32'(j);
      mdl[key(inst, b)] = wd[8*(int'(b) % bytes_of(inst)) +: 8];
    end
  endtask

  task automatic model_read(input int inst, input logic [31:0] a,
                            output logic [63:0] d, output logic [63:0] m);
    logic [31:0] base;
    base = a & ~32'(bytes_of(inst) - 1);
    d = '0;
    m = '1;
    for (int j = 0; j < bytes_of(inst); j++) begin
      if (mdl.exists(key(inst, base + 32'(j)))) d[8*j +: 8] = mdl[key(inst, base + 32'(j))];
      else m[8*j +: 8] = 8'h00;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp,
                     input logic [63:0] mask);
    checks++;
    if (((act ^ exp) & mask) !== 64'd0) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h) at %0t", nm, act, exp, mask, $time);
    end
  endtask

  task automatic observe(input int inst, output logic r, output logic [1:0] rs,
                         output logic [63:0] rd);
    case (inst)
      0:       begin r = rdy[0]; rs = resp0; rd = {32'd0, rdata0}; end
      1:       begin r = rdy[1]; rs = resp1; rd = {32'd0, rdata1}; end
      default: begin r = rdy[2]; rs = resp2; rd = rdata2; end
    endcase
  endtask

  // Pipelined master over seq[] aimed at one instance; called just after a rising edge.
  task automatic run_seq(input int inst);
    int k, n, stalls, guard;
    bit have_dp, exp_err;
    vec_t dp, cur;
    logic r;
    logic [1:0] rs;
    logic [63:0] rd, last_wd, exp_rd, exp_m;
    n = seq.size(); k = 0; stalls = 0; guard = 0; have_dp = 0; last_wd = '0;
    dp = mk(0, TR_IDLE, 0, 3'd0, 32'd0, 64'd0, 0, 0, 64'd0);
    while ((k < n || have_dp) && guard < 20*n + 50) begin
      guard++;
      if (k < n) begin
        cur = seq[k];
        hsel_v = cur.sel ? 3'(1 << inst) : 3'b000;
        htrans = cur.trans; hwrite = cur.wr; hsize = cur.size; haddr = cur.addr;
      end else begin
        hsel_v = '0; htrans = TR_IDLE; hwrite = 1'b0; hsize = '0; haddr = '0;
      end
      hwdata = last_wd;
      @(negedge hclk);
      observe(inst, r, rs, rd);
      if (have_dp) begin
        exp_err = dp.has_exp ? dp.exp_err : model_err(inst, dp.size, dp.addr);
        if (!r) begin
          stalls++;
          chk("stall_resp", 64'(rs), exp_err ? 64'd1 : 64'd0, '1);
          chk("stall_rdata", rd, 64'd0, '1);
          if (stalls > 10) begin
            checks++; errors++;
            $display("FAIL stall_timeout: inst %0d addr %h still not ready", inst, dp.addr);
            have_dp = 0; k = n;
          end
        end else begin
          chk("wait_cycles", 64'(stalls), exp_err ? 64'd1 : 64'(ws_of(inst)), '1);
          chk("resp", 64'(rs), exp_err ? 64'd1 : 64'd0, '1);
          exp_rd = '0; exp_m = '1;
          if (!exp_err && !dp.wr) begin
            if (dp.has_exp) exp_rd = dp.exp_rdata;
            else model_read(inst, dp.addr, exp_rd, exp_m);
          end
          chk(dp.wr ? "wr_rdata" : "rd_rdata", rd, exp_rd, exp_m);
          if (dp.wr && !model_err(inst, dp.size, dp.addr))
            model_write(inst, dp.size, dp.addr, dp.wdata);
          have_dp = 0;
        end
      end else begin
        chk("idle_ready", 64'(r), 64'd1, '1);
        chk("idle_resp", 64'(rs), 64'd0, '1);
        chk("idle_rdata", rd, 64'd0, '1);
      end
      @(posedge hclk); #1;
      if (r && k < n) begin
        last_wd = seq[k].wdata;
        if (seq[k].sel && seq[k].trans[1]) begin
          dp = seq[k]; have_dp = 1; stalls = 0;
        end
        k++;
      end
    end
    if (k < n || have_dp) begin
      checks++; errors++;
      $display("FAIL seq_timeout: inst %0d stopped at vector %0d of %0d", inst, k, n);
    end
    hsel_v = '0; htrans = TR_IDLE; hwdata = '0;
  endtask

  task automatic gen_random(input int inst, input int cnt);
    vec_t v;
    int bl, nbytes, dl, sz, nb, word, r, q, p;
    logic [31:0] a;
    bl = lg_of(inst); nbytes = bytes_of(inst); dl = dlog_of(inst);
    seq.delete();
    for (int t = 0; t < cnt; t++) begin
      p  = int'($urandom_range(0, 99));
      sz = int'($urandom_range(0, bl));
      nb = 1 << sz;
      r  = int'($urandom_range(0, 15));
      word = (r < 8) ? r : (1 << dl) - 16 + r;
      a = 32'(word * nbytes + int'($urandom_range(0, nbytes / nb - 1)) * nb);
      q = int'($urandom_range(0, 19));
      if (q == 0) a = a + 32'((1 << dl) * nbytes);
      if (q == 1) sz = bl + 1;
      if (q == 2) a = a + 32'd1;
      if (q == 3) a = a | 32'h8000_0000;
      v = mk(($urandom_range(0, 9) != 0),
             (p < 8) ? TR_IDLE : (p < 14) ? TR_BUSY : (p < 60) ? TR_NS : TR_SQ,
             $urandom_range(0, 1) == 1, 3'(sz), a, {$urandom(), $urandom()},
             0, 0, 64'd0);
      seq.push_back(v);
    end
  endtask

  initial begin
    logic r;
    logic [1:0] rs;
    logic [63:0] rd;

    #2;
    for (int i = 0; i < 3; i++) begin
      observe(i, r, rs, rd);
      chk("reset_ready", 64'(r), 64'd1, '1);
      chk("reset_resp", 64'(rs), 64'd0, '1);
      chk("reset_rdata", rd, 64'd0, '1);
    end
    @(posedge hclk);
    @(negedge hclk); hreset = 1'b0;
    @(posedge hclk); #1;

    // 32-bit, zero wait
    seq.delete();
    seq.push_back(mk(1, TR_NS,   1, 3'd2, 32'h0,    64'hDEADBEEF, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_SQ,   1, 3'd2, 32'h4,    64'h12345678, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS,   0, 3'd2, 32'h0,    64'd0,        1, 0, 64'hDEADBEEF));
    seq.push_back(mk(1, TR_SQ,   0, 3'd2, 32'h4,    64'd0,        1, 0, 64'h12345678));
    seq.push_back(mk(1, TR_NS,   1, 3'd2, 32'h8,    64'hCAFEF00D, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS,   0, 3'd2, 32'h1000, 64'd0,        1, 1, 64'd0));
    seq.push_back(mk(1, TR_NS,   1, 3'd1, 32'h1,    64'hFFFFFFFF, 1, 1, 64'd0));
    seq.push_back(mk(1, TR_NS,   1, 3'd3, 32'h8,    64'hFFFFFFFF, 1, 1, 64'd0));
    seq.push_back(mk(1, TR_NS,   0, 3'd2, 32'h0,    64'd0,        1, 0, 64'hDEADBEEF));
    seq.push_back(mk(1, TR_NS,   0, 3'd2, 32'h8,    64'd0,        1, 0, 64'hCAFEF00D));
    seq.push_back(mk(1, TR_NS,   1, 3'd2, 32'h10,   64'hA5A55A5A, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS,   0, 3'd2, 32'h10,   64'h0,        1, 0, 64'hA5A55A5A));
    seq.push_back(mk(1, TR_IDLE, 1, 3'd2, 32'h10,   64'h0,        1, 0, 64'd0));
    seq.push_back(mk(1, TR_BUSY, 1, 3'd2, 32'h10,   64'h1111,     1, 0, 64'd0));
    seq.push_back(mk(0, TR_NS,   1, 3'd2, 32'h10,   64'h2222,     1, 0, 64'd0));
    seq.push_back(mk(0, TR_NS,   0, 3'd2, 32'h10,   64'h3333,     1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS,   0, 3'd2, 32'h10,   64'h0,        1, 0, 64'hA5A55A5A));
    seq.push_back(mk(1, TR_NS,   1, 3'd0, 32'h11,   64'h0000CC00, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS,   1, 3'd1, 32'h12,   64'h77660000, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS,   0, 3'd2, 32'h10,   64'h0,        1, 0, 64'h7766CC5A));
    seq.push_back(mk(1, TR_NS,   1, 3'd2, 32'hFFC,  64'h0BADCAFE, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS,   0, 3'd2, 32'hFFC,  64'h0,        1, 0, 64'h0BADCAFE));
    run_seq(0);

    // 32-bit, three wait states
    seq.delete();
    seq.push_back(mk(1, TR_NS, 1, 3'd2, 32'h20,   64'h11223344, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS, 0, 3'd2, 32'h20,   64'h0,        1, 0, 64'h11223344));
    seq.push_back(mk(1, TR_NS, 0, 3'd2, 32'h1000, 64'h0,        1, 1, 64'd0));
    seq.push_back(mk(1, TR_NS, 1, 3'd2, 32'h22,   64'hFFFFFFFF, 1, 1, 64'd0));
    seq.push_back(mk(1, TR_NS, 0, 3'd2, 32'h20,   64'h0,        1, 0, 64'h11223344));
    seq.push_back(mk(1, TR_NS, 1, 3'd2, 32'h8,    64'h0,        1, 0, 64'd0));
    run_seq(1);

    // Reset during the WAIT of a write to 0x8 (holding 0)
    hsel_v = 3'b010; htrans = TR_NS; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h8; hwdata = '0;
    @(posedge hclk); #1;
    hsel_v = '0; htrans = TR_IDLE; hwrite = 1'b0; hwdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge hclk);
    chk("rst_pre_ready", 64'(rdy[1]), 64'd0, '1);
    @(posedge hclk); #1;
    hreset = 1'b1; #1;
    chk("rst_async_ready", 64'(rdy[1]), 64'd1, '1);
    chk("rst_async_resp", 64'(resp1), 64'd0, '1);
    chk("rst_async_rdata", 64'(rdata1), 64'd0, '1);
    @(posedge hclk);
    @(negedge hclk); hreset = 1'b0; hwdata = '0;
    @(posedge hclk); #1;
    seq.delete();
    seq.push_back(mk(1, TR_NS, 0, 3'd2, 32'h8, 64'h0, 1, 0, 64'h0));
    run_seq(1);

    // 64-bit, two wait states, 256 words
    seq.delete();
    seq.push_back(mk(1, TR_NS, 1, 3'd3, 32'h0,   64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS, 1, 3'd0, 32'h2,   64'h0000_0000_00AB_0000, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS, 0, 3'd3, 32'h0,   64'h0, 1, 0, 64'hFFFF_FFFF_FFAB_FFFF));
    seq.push_back(mk(1, TR_NS, 0, 3'd3, 32'h800, 64'h0, 1, 1, 64'd0));
    seq.push_back(mk(1, TR_NS, 1, 3'd3, 32'h7F8, 64'h0123_4567_89AB_CDEF, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS, 0, 3'd3, 32'h7F8, 64'h0, 1, 0, 64'h0123_4567_89AB_CDEF));
    seq.push_back(mk(1, TR_NS, 1, 3'd3, 32'h4,   64'h0, 1, 1, 64'd0));
    seq.push_back(mk(1, TR_NS, 0, 3'd4, 32'h0,   64'h0, 1, 1, 64'd0));
    seq.push_back(mk(1, TR_NS, 1, 3'd2, 32'h4,   64'h5566_7788_0000_0000, 1, 0, 64'd0));
    seq.push_back(mk(1, TR_NS, 0, 3'd2, 32'h4,   64'h0, 1, 0, 64'h5566_7788_FFAB_FFFF));
    run_seq(2);

    for (int i = 0; i < 3; i++) begin
      gen_random(i, 150);
      run_seq(i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
